// File: rtl/conv_output_reorder.sv
// ============================================================================
// Module   : conv_output_reorder
// Purpose  : Buffers one channel-group-major conv layer and re-emits it pixel-major (NHWC).
//            Optional CONVOUT_LAST_EN adds an mData_last end-of-layer marker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_output_reorder #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4096,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  In_Channel,
    input  logic [CNT_W-1:0]  Matrix_Col,
    input  logic [CNT_W-1:0]  Matrix_Row,
    input  logic [DATA_W-1:0] sData,
    input  logic              sValid,
    output logic              sReady,
    output logic [DATA_W-1:0] mData_payload,
    output logic              mData_valid,
`ifdef CONVOUT_LAST_EN
    output logic              mData_last,
`endif
    input  logic              mData_ready
);

    localparam int c_ADDR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DRAIN   = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cg;        // channel groups per pixel
    logic [CNT_W-1:0]   r_p;         // pixels per layer
    logic [CNT_W-1:0]   r_n;         // words per layer
    logic [CNT_W-1:0]   r_in_cnt;
    logic [CNT_W-1:0]   r_pix_cnt;
    logic [CNT_W-1:0]   r_cg_cnt;
    logic [CNT_W-1:0]   r_waddr;
    logic [CNT_W-1:0]   r_raddr;
    logic [DATA_W-1:0]  r_mem [DEPTH];

    logic [CNT_W-1:0]   w_cg_in;
    logic [CNT_W-1:0]   w_p_in;
    logic [CNT_W-1:0]   w_n_in;
    logic               w_empty;
    logic               w_in_fire;
    logic               w_out_fire;
    logic               w_ren;

    // Layer size products are only formed once per start; the write path stays adder-only.
    assign w_cg_in    = In_Channel >> 3;
    assign w_p_in     = Matrix_Row * Matrix_Col;
    assign w_n_in     = w_p_in * w_cg_in;
    assign w_empty    = (w_cg_in == '0) || (Matrix_Row == '0) || (Matrix_Col == '0);
    assign w_in_fire  = sValid && sReady;
    assign w_out_fire = mData_valid && mData_ready;
    assign w_ren      = (r_state == S_DRAIN) && (r_raddr < r_n) && (!mData_valid || mData_ready);

    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_mem[r_waddr[c_ADDR_W-1:0]] <= sData;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cg          <= '0;
            r_p           <= '0;
            r_n           <= '0;
            r_in_cnt      <= '0;
            r_pix_cnt     <= '0;
            r_cg_cnt      <= '0;
            r_waddr       <= '0;
            r_raddr       <= '0;
            sReady        <= 1'b0;
            mData_valid   <= 1'b0;
            mData_payload <= '0;
`ifdef CONVOUT_LAST_EN
            mData_last    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cg      <= w_cg_in;
                        r_p       <= w_p_in;
                        r_n       <= w_n_in;
                        r_in_cnt  <= '0;
                        r_pix_cnt <= '0;
                        r_cg_cnt  <= '0;
                        r_waddr   <= '0;
                        r_raddr   <= '0;
                        if (!w_empty) begin
                            r_state <= S_COLLECT;
                            sReady  <= 1'b1;
                        end
                    end
                end

                S_COLLECT: begin
                    if (w_in_fire) begin
                        r_in_cnt <= r_in_cnt + CNT_W'(1);
                        if (r_pix_cnt == r_p - CNT_W'(1)) begin
                            r_pix_cnt <= '0;
                            r_cg_cnt  <= r_cg_cnt + CNT_W'(1);
                            r_waddr   <= r_cg_cnt + CNT_W'(1);
                        end else begin
                            r_pix_cnt <= r_pix_cnt + CNT_W'(1);
                            r_waddr   <= r_waddr + r_cg;
                        end
                        if (r_in_cnt == r_n - CNT_W'(1)) begin
                            r_state <= S_DRAIN;
                            sReady  <= 1'b0;
                        end
                    end
                end

                S_DRAIN: begin
                    if (w_ren) begin
                        mData_payload <= r_mem[r_raddr[c_ADDR_W-1:0]];
                        mData_valid   <= 1'b1;
                        r_raddr       <= r_raddr + CNT_W'(1);
`ifdef CONVOUT_LAST_EN
                        mData_last    <= (r_raddr == r_n - CNT_W'(1));
`endif
                    end else if (w_out_fire) begin
                        // Only reachable once every address has been read: layer done.
                        mData_valid <= 1'b0;
`ifdef CONVOUT_LAST_EN
                        mData_last  <= 1'b0;
`endif
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    sReady  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_conv_output_reorder.sv
// ============================================================================
// Module   : tb_conv_output_reorder
// Purpose  : Randomized self-checking bench with a queue-based NHWC reorder model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conv_output_reorder;

    localparam int DW = 64;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [CW-1:0] in_ch, m_col, m_row;
    logic [DW-1:0] s_data;
    logic          s_valid, s_ready;
    logic [DW-1:0] m_pay;
    logic          m_valid, m_ready;
`ifdef CONVOUT_LAST_EN
    logic          m_last;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    conv_output_reorder dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .In_Channel    (in_ch),
        .Matrix_Col    (m_col),
        .Matrix_Row    (m_row),
        .sData         (s_data),
        .sValid        (s_valid),
        .sReady        (s_ready),
        .mData_payload (m_pay),
        .mData_valid   (m_valid),
`ifdef CONVOUT_LAST_EN
        .mData_last    (m_last),
`endif
        .mData_ready   (m_ready)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start(input int rows, input int cols, input int chans);
        m_row = CW'(rows);
        m_col = CW'(cols);
        in_ch = CW'(chans);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // abort_in / abort_out >= 0 assert reset after that many accepts / beats.
    task automatic run_layer(input int rows, input int cols, input int chans,
                             input int vpct, input int rpct, input bit poke,
                             input bit seqdata, input int abort_in, input int abort_out);
        logic [63:0] in_q[$];
        logic [63:0] exp_q[$];
        logic [63:0] prev_pay;
        int p, ncg, n, acc, beats, cycles, budget;
        bit prev_stall, poked_c, poked_d, rdy_checked, in_fire, out_fire;
        p   = rows * cols;
        ncg = chans / 8;
        n   = p * ncg;
        for (int j = 0; j < n; j++)
            in_q.push_back(seqdata ? 64'(j) : {$urandom, $urandom});
        // NHWC order: pixel outer, channel group inner.
        for (int pp = 0; pp < p; pp++)
            for (int g = 0; g < ncg; g++)
                exp_q.push_back(in_q[g * p + pp]);

        pulse_start(rows, cols, chans);
        chk("srdy_after_start", 64'(s_ready), 64'(1));

        acc = 0; beats = 0; cycles = 0; budget = n * 20 + 100;
        prev_stall = 0; prev_pay = '0; poked_c = 0; poked_d = 0; rdy_checked = 0;
        while (beats < n && cycles < budget) begin
            if (prev_stall) begin
                chk("stall_valid", 64'(m_valid), 64'(1));
                chk("stall_payload", m_pay, prev_pay);
            end
            if (acc == n && !rdy_checked) begin
                chk("srdy_low_in_drain", 64'(s_ready), 64'(0));
                rdy_checked = 1;
            end
            s_valid = (acc < n) && ($urandom_range(99) < vpct);
            s_data  = (acc < n) ? in_q[acc] : '0;
            m_ready = ($urandom_range(99) < rpct);
            start   = 1'b0;
            if (poke && !poked_c && acc == n / 2) begin
                start = 1'b1; m_row = 2; m_col = 2; in_ch = 8; poked_c = 1;
            end else if (poke && !poked_d && acc == n && beats == n / 2) begin
                start = 1'b1; m_row = 3; m_col = 1; in_ch = 16; poked_d = 1;
            end
            in_fire  = s_valid && s_ready;
            out_fire = m_valid && m_ready;
            if (out_fire) begin
                chk("data", m_pay, exp_q[beats]);
`ifdef CONVOUT_LAST_EN
                chk("last", 64'(m_last), 64'(beats == n - 1));
`endif
                beats++;
            end
            prev_stall = m_valid && !m_ready;
            prev_pay   = m_pay;
            if (in_fire) acc++;
            if ((abort_in >= 0 && acc == abort_in) || (abort_out >= 0 && beats == abort_out)) begin
                reset   = 1'b1;
                start   = 1'b0;
                s_valid = 1'b0;
                m_ready = 1'b0;
                @(posedge clk); #1;
                chk("abort_srdy", 64'(s_ready), 64'(0));
                chk("abort_valid", 64'(m_valid), 64'(0));
                chk("abort_payload", m_pay, 64'(0));
`ifdef CONVOUT_LAST_EN
                chk("abort_last", 64'(m_last), 64'(0));
`endif
                reset = 1'b0;
                return;
            end
            @(posedge clk); #1;
            cycles++;
        end
        start   = 1'b0;
        s_valid = 1'b0;
        chk("beat_count", 64'(beats), 64'(n));
        chk("idle_valid", 64'(m_valid), 64'(0));
        chk("idle_srdy", 64'(s_ready), 64'(0));
        if (vpct == 100 && rpct == 100 && !poke)
            chk("full_rate_cycles", 64'(cycles), 64'(2 * n + 1));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        s_data = '0; in_ch = '0; m_col = '0; m_row = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_srdy", 64'(s_ready), 64'(0));
        chk("rst_valid", 64'(m_valid), 64'(0));
        chk("rst_payload", m_pay, 64'(0));
        reset = 1'b0;
        @(posedge clk); #1;

        run_layer(14, 14, 32, 100, 100, 0, 1, -1, -1);
        run_layer(4, 4, 8, 100, 100, 0, 1, -1, -1);
        run_layer(14, 14, 32, 60, 50, 1, 0, -1, -1);
        run_layer(5, 3, 24, 70, 40, 0, 0, -1, -1);

        // Empty layer must not leave IDLE.
        pulse_start(0, 5, 16);
        repeat (2) begin
            chk("empty_srdy", 64'(s_ready), 64'(0));
            @(posedge clk); #1;
        end
        pulse_start(4, 4, 4);
        chk("cg0_srdy", 64'(s_ready), 64'(0));

        run_layer(14, 14, 32, 80, 80, 0, 0, 300, -1);
        run_layer(14, 14, 32, 80, 80, 0, 0, -1, -1);
        run_layer(6, 5, 16, 80, 60, 0, 0, -1, 25);
        run_layer(6, 5, 16, 90, 60, 0, 0, -1, -1);

        for (int k = 0; k < 4; k++)
            run_layer($urandom_range(1, 6), $urandom_range(1, 6), 8 * $urandom_range(1, 4),
                      $urandom_range(30, 100), $urandom_range(30, 100), 1'($urandom_range(1)), 0, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/conv_output_reorder.md
# conv_output_reorder

Output-side reorder buffer for the systolic convolution engine. The array emits results channel-group-major: for each group of 8 output channels, every output pixel in raster order. This block buffers one full output layer and re-emits it pixel-major (NHWC): for each pixel, all channel groups in order. Each 64-bit word carries 8 int8 channels.

## Interface
- `DATA_W`, 64: word width; 8 lanes × 8 bit.
- `DEPTH`, 4096: buffer capacity in words.
- `CNT_W`, 16: width of dimension inputs and internal counters.

- `clk`  in  1  single clock; all logic rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; latches configuration and begins a layer.
- `In_Channel`  in  CNT_W  output channel count; multiple of 8; CG = In_Channel>>3.
- `Matrix_Col`  in  CNT_W  output feature-map width.
- `Matrix_Row`  in  CNT_W  output feature-map height.
- `sData`  in  DATA_W  input word from the array.
- `sValid`  in  1  input valid.
- `sReady`  out  1  input ready.
- `mData_payload`  out  DATA_W  reordered output word.
- `mData_valid`  out  1  output valid.
- `mData_ready`  in  1  downstream ready.

## Operation
- Definitions: P = Matrix_Row*Matrix_Col; N = P*CG. The caller guarantees N ≤ DEPTH; the block does not check this.
- States: IDLE, COLLECT, DRAIN.
- IDLE: `sReady`=0. On `start`, the block registers In_Channel, Matrix_Col and Matrix_Row, and clears all counters.
  - If N==0, it stays in IDLE.
  - Otherwise it moves to COLLECT.
- COLLECT: `sReady`=1.
  - Input word j (j=0..N-1) belongs to group cg = j / P and pixel p = j % P.
  - It is written to buffer address p*CG + cg.
  - The address is computed incrementally with no multiplier in the datapath:
    - waddr starts at 0 and adds CG on each accept;
    - when the pixel counter wraps at P, cg increments and waddr := cg.
  - After the Nth accept, the state moves to DRAIN.
- DRAIN: `sReady`=0. The buffer is read sequentially at addresses 0..N-1 and each word is emitted on `mData_payload`. When the last word is accepted, the state returns to IDLE.
- `start` is ignored in COLLECT and DRAIN.
- Buffer: single-port or simple dual-port RAM, DATA_W × DEPTH.
  - Synchronous read, 1-cycle latency.
  - The read data register holds its value while read-enable is low.

## Timing
- Reset values: state=IDLE, `sReady`=0, `mData_valid`=0, `mData_payload`=0, all counters 0.
- Reset asserted mid-layer aborts the layer immediately. Buffer contents are don't-care afterward.
- `start` is sampled on the rising edge. COLLECT begins the next cycle, so `sReady` is high 1 cycle after `start`.
- Input handshake: a transfer occurs when `sValid` && `sReady`. One word is accepted per cycle maximum. `sReady` is a registered state decode.
- DRAIN entry: the cycle after the Nth input accept.
  - The first read is issued in the first DRAIN cycle.
  - `mData_valid` rises the following cycle.
- Read enable: ren = (raddr < N) && (!`mData_valid` || `mData_ready`).
- `mData_valid` behaviour:
  - set on the cycle after a read is issued;
  - cleared when the word is accepted and no read was issued.
- Throughput: with `mData_ready` held at 1, one word per cycle.
- Backpressure: `mData_payload` and `mData_valid` stay stable while `mData_valid`=1 and `mData_ready`=0.
- Layer cadence: IDLE is reached the cycle after the final output accept. A new `start` is accepted from that cycle onward.

## Configuration
- `CONVOUT_LAST_EN`: when defined, the block adds an output port `mData_last` (1 bit).
  - `mData_last` is high with `mData_valid` on output word N-1 only.
  - Reset value is 0.
- When `CONVOUT_LAST_EN` is undefined, the port and its logic are absent; all other behaviour is identical.

## Test plan
- Nominal 14×14×32 layer (P=196, CG=4, N=784): feed payload = input index j, with `sValid` and `mData_ready` held at 1.
  - Output sequence must be 0,196,392,588,1,197,393,589,…,195,391,587,783.
  - Exactly 784 output beats.
  - `sReady` is low after 784 input accepts.
- In_Channel=8, 4×4: output order equals input order 0..15, with no gaps.
- Backpressure during DRAIN: toggle `mData_ready` in a pseudo-random pattern (e.g. ~50% duty).
  - Sequence is unchanged with no loss or duplication.
  - Payload is stable while stalled.
- `sValid` gaps during COLLECT: the same 14×14×32 ordering still holds.
- `start` pulsed in COLLECT and in DRAIN: ignored, layer completes normally. A `start` after IDLE returns runs a second layer correctly.
- `reset` asserted mid-COLLECT and mid-DRAIN: all outputs are 0 next cycle and the state is IDLE. A following `start` runs a full layer correctly.
- With `CONVOUT_LAST_EN`: `mData_last`=1 only on word 783 of the 14×14×32 layer.
